// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: access-size masks, FSM encoding
// and the alignment/legality check.
package mem_stage_pkg;

   localparam logic [3:0] MEM_B = 4'b0001;
   localparam logic [3:0] MEM_H = 4'b0011;
   localparam logic [3:0] MEM_W = 4'b1111;

   typedef enum logic [0:0] {
      StIdle,
      StBusy
   } mem_state_e;

   // True when the mask is a legal size and the byte offset is naturally aligned for it.
   function automatic logic access_ok(input logic [3:0] mask, input logic [1:0] off);
      logic ok;
      case (mask)
         MEM_B:   ok = 1'b1;
         MEM_H:   ok = ~off[0];
         MEM_W:   ok = (off == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data lane select and sign/zero extension; purely combinational.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [3:0]  size,
   input  logic        sext,
   output logic [31:0] result
);

   logic [31:0] shifted;

   assign shifted = rdata >> {addr, 3'b000};

   always_comb begin
      result = shifted;
      case (size)
         MEM_B:   result = {{24{sext & shifted[7]}}, shifted[7:0]};
         MEM_H:   result = {{16{sext & shifted[15]}}, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one outstanding req/ack data-memory transaction, load alignment
// and register-file writeback. All outputs are registered.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DMEM_AW = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               EX_x_rd_vld,
   input  logic [31:0]        EX_x_rd,
   input  logic [4:0]         EX_rd_idx,
   input  logic [31:0]        EX_MEMaddr,
   input  logic [3:0]         EX_MEMrden,
   input  logic               EX_MEMrden_SEXT,
   input  logic [3:0]         EX_MEMwren,
   input  logic [31:0]        EX_MEMwrdata,
   output logic               MEM_stall,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic [3:0]         dmem_be,
   output logic [31:0]        dmem_wdata,
   input  logic               dmem_ack,
   input  logic [31:0]        dmem_rdata,
   output logic               WB_x_rd_vld,
   output logic [4:0]         WB_rd_idx,
   output logic [31:0]        WB_x_rd,
   output logic               MEM_err
);

   mem_state_e state_q, state_d;

   logic               we_q, we_d;
   logic [DMEM_AW-1:0] addr_q, addr_d;
   logic [3:0]         be_q, be_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         size_q, size_d;
   logic               sext_q, sext_d;
   logic [1:0]         off_q, off_d;
   logic [4:0]         ld_idx_q, ld_idx_d;
   logic               ld_vld_q, ld_vld_d;
   logic               wb_vld_q, wb_vld_d;
   logic [4:0]         wb_idx_q, wb_idx_d;
   logic [31:0]        wb_data_q, wb_data_d;
   logic               err_q, err_d;

   logic               is_nop, is_load, is_store, op_ok;
   logic [1:0]         off;
   logic [3:0]         mask_sel;
   logic [DMEM_AW-1:0] addr_full;
   logic [31:0]        load_data;

   assign off       = EX_MEMaddr[1:0];
   assign addr_full = DMEM_AW'(EX_MEMaddr);
   assign is_nop    = (EX_MEMrden == 4'b0000) && (EX_MEMwren == 4'b0000);
   assign is_load   = (EX_MEMrden != 4'b0000) && (EX_MEMwren == 4'b0000);
   assign is_store  = (EX_MEMwren != 4'b0000) && (EX_MEMrden == 4'b0000);
   assign mask_sel  = is_load ? EX_MEMrden : EX_MEMwren;
   assign op_ok     = (is_load || is_store) && access_ok(mask_sel, off);

   mem_load_align u_load_align (
      .rdata  (dmem_rdata),
      .addr   (off_q),
      .size   (size_q),
      .sext   (sext_q),
      .result (load_data)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (op_ok) state_d = StBusy;
         StBusy:  if (dmem_ack) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs; req drops together with an asynchronous reset of the state
   always_comb begin
      dmem_req  = (state_q == StBusy);
      MEM_stall = (state_q == StBusy);
   end

   always_comb begin
      we_d      = we_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      size_d    = size_q;
      sext_d    = sext_q;
      off_d     = off_q;
      ld_idx_d  = ld_idx_q;
      ld_vld_d  = ld_vld_q;
      wb_vld_d  = 1'b0;
      wb_idx_d  = wb_idx_q;
      wb_data_d = wb_data_q;
      err_d     = 1'b0;
      if (state_q == StIdle) begin
         if (is_nop) begin
            wb_vld_d  = EX_x_rd_vld;
            wb_idx_d  = EX_rd_idx;
            wb_data_d = EX_x_rd;
         end else if (op_ok) begin
            we_d     = is_store;
            addr_d   = {addr_full[DMEM_AW-1:2], 2'b00};
            be_d     = mask_sel << off;
            wdata_d  = is_store ? (EX_MEMwrdata << {off, 3'b000}) : 32'h0;
            size_d   = mask_sel;
            sext_d   = EX_MEMrden_SEXT;
            off_d    = off;
            ld_idx_d = EX_rd_idx;
            ld_vld_d = EX_x_rd_vld;
         end else begin
            err_d = 1'b1;
         end
      end else if (dmem_ack && !we_q) begin
         wb_vld_d  = ld_vld_q;
         wb_idx_d  = ld_idx_q;
         wb_data_d = load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= 4'b0000;
         wdata_q   <= 32'h0;
         size_q    <= 4'b0000;
         sext_q    <= 1'b0;
         off_q     <= 2'b00;
         ld_idx_q  <= 5'd0;
         ld_vld_q  <= 1'b0;
         wb_vld_q  <= 1'b0;
         wb_idx_q  <= 5'd0;
         wb_data_q <= 32'h0;
         err_q     <= 1'b0;
      end else begin
         we_q      <= we_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         size_q    <= size_d;
         sext_q    <= sext_d;
         off_q     <= off_d;
         ld_idx_q  <= ld_idx_d;
         ld_vld_q  <= ld_vld_d;
         wb_vld_q  <= wb_vld_d;
         wb_idx_q  <= wb_idx_d;
         wb_data_q <= wb_data_d;
         err_q     <= err_d;
      end
   end

   assign dmem_we     = we_q;
   assign dmem_addr   = addr_q;
   assign dmem_be     = be_q;
   assign dmem_wdata  = wdata_q;
   assign WB_x_rd_vld = wb_vld_q;
   assign WB_rd_idx   = wb_idx_q;
   assign WB_x_rd     = wb_data_q;
   assign MEM_err     = err_q;

endmodule
